// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequenced 32x32 vedic multiplier.
// Optional macro VEDIC32_SIGNED_EN (handled in the interface and top) adds the CORR step.
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned HALF_W = OP_W / 2;
  localparam int unsigned NUM_PP = 4;

  // Left shift applied to each half-product, indexed by the step counter
  localparam int unsigned PP_SHIFT [NUM_PP] = '{0, 16, 16, 32};

endpackage

// File: rtl/vedic32_seq_ctrl_if.sv
// Operand/result handshake bundle for vedic32_seq_ctrl.
// Macro VEDIC32_SIGNED_EN adds the in_signed operand qualifier.
interface vedic32_seq_ctrl_if #(
  parameter int OP_W = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     in_a;
  logic [OP_W-1:0]     in_b;
`ifdef VEDIC32_SIGNED_EN
  logic                in_signed;
`endif
  logic                out_valid;
  logic                out_ready;
  logic [2*OP_W-1:0]   out_p;

  // Operand source / result consumer side
  modport master (
    output in_valid, in_a, in_b,
`ifdef VEDIC32_SIGNED_EN
    output in_signed,
`endif
    output out_ready,
    input  in_ready, out_valid, out_p
  );

  // Controller side
  modport slave (
    input  in_valid, in_a, in_b,
`ifdef VEDIC32_SIGNED_EN
    input  in_signed,
`endif
    input  out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/vedic_16x16.sv
// Combinational 16x16 -> 32 vedic multiplier built from four 8x8 crosswise products.
module vedic_16x16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);
  logic [15:0] w_ll;
  logic [15:0] w_hl;
  logic [15:0] w_lh;
  logic [15:0] w_hh;

  assign w_ll = {8'b0, i_a[7:0]}  * {8'b0, i_b[7:0]};
  assign w_hl = {8'b0, i_a[15:8]} * {8'b0, i_b[7:0]};
  assign w_lh = {8'b0, i_a[7:0]}  * {8'b0, i_b[15:8]};
  assign w_hh = {8'b0, i_a[15:8]} * {8'b0, i_b[15:8]};

  assign o_p = {16'b0, w_ll}
             + {8'b0, w_hl, 8'b0}
             + {8'b0, w_lh, 8'b0}
             + {w_hh, 16'b0};
endmodule

// File: rtl/vedic32_seq_ctrl.sv
// Sequencing controller: 32x32 -> 64 product from one shared vedic_16x16 over four cycles.
// Macro VEDIC32_SIGNED_EN: adds in_signed and a one-cycle CORR step for two's-complement operands.
module vedic32_seq_ctrl
  import vedic_pkg::*;
#(
  parameter int OP_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  vedic32_seq_ctrl_if.slave bus,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_cnt;
  logic [OP_W-1:0]     r_a;
  logic [OP_W-1:0]     r_b;
  logic [2*OP_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_op_count;
`ifdef VEDIC32_SIGNED_EN
  logic                r_signed;
  logic [2*OP_W-1:0]   w_corr_a;
  logic [2*OP_W-1:0]   w_corr_b;
`endif

  logic                w_accept;
  logic                w_handoff;
  logic [HALF_W-1:0]   w_ha;
  logic [HALF_W-1:0]   w_hb;
  logic [2*HALF_W-1:0] w_pp;
  logic [2*OP_W-1:0]   w_pp_sh;

  assign w_accept  = bus.in_valid && (r_state == IDLE);
  assign w_handoff = bus.out_ready && (r_state == DONE);

  // cnt bit 0 picks the high half of a, bit 1 the high half of b
  assign w_ha = r_cnt[0] ? r_a[OP_W-1:HALF_W] : r_a[HALF_W-1:0];
  assign w_hb = r_cnt[1] ? r_b[OP_W-1:HALF_W] : r_b[HALF_W-1:0];

  vedic_16x16 u_mul (
    .i_a (w_ha),
    .i_b (w_hb),
    .o_p (w_pp)
  );

  assign w_pp_sh = {{OP_W{1'b0}}, w_pp} << PP_SHIFT[r_cnt];

`ifdef VEDIC32_SIGNED_EN
  // Unsigned product minus the weight of each negative operand's sign bit
  assign w_corr_a = r_a[OP_W-1] ? {r_b, {OP_W{1'b0}}} : '0;
  assign w_corr_b = r_b[OP_W-1] ? {r_a, {OP_W{1'b0}}} : '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = MUL;
      MUL: begin
        if (r_cnt == 2'(NUM_PP - 1)) begin
`ifdef VEDIC32_SIGNED_EN
          w_next = CORR;
`else
          w_next = DONE;
`endif
        end
      end
`ifdef VEDIC32_SIGNED_EN
      CORR: w_next = DONE;
`endif
      DONE: if (w_handoff) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, shift-accumulate, correction and hand-off counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_op_count <= '0;
`ifdef VEDIC32_SIGNED_EN
      r_signed   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= bus.in_a;
            r_b   <= bus.in_b;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef VEDIC32_SIGNED_EN
            r_signed <= bus.in_signed;
`endif
          end
        end
        MUL: begin
          r_acc <= r_acc + w_pp_sh;
          r_cnt <= r_cnt + 2'd1;
        end
`ifdef VEDIC32_SIGNED_EN
        CORR: begin
          if (r_signed) r_acc <= r_acc - w_corr_a - w_corr_b;
        end
`endif
        DONE: begin
          if (w_handoff) r_op_count <= r_op_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_p     = r_acc;
  assign busy          = (r_state != IDLE);
  assign op_count      = r_op_count;

endmodule

// File: tb/tb_vedic32_seq_ctrl.sv
// Scoreboard bench for vedic32_seq_ctrl with directed operand vectors.
// Honours VEDIC32_SIGNED_EN (adds signed vectors, latency 5).
module tb_vedic32_seq_ctrl;

  localparam int CNT_W = 3;
`ifdef VEDIC32_SIGNED_EN
  localparam int unsigned LAT = 5;
`else
  localparam int unsigned LAT = 4;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  vedic32_seq_ctrl_if #(.OP_W(32)) bus();

  vedic32_seq_ctrl #(.OP_W(32), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0]      p;
    logic [CNT_W-1:0] cnt;
    int unsigned      acc_cyc;
  } exp_t;

  exp_t             sb[$];
  int               n_cmp = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_count = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Present operands until accepted; returns the cycle of the accepting edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] p, input bit hold, output int unsigned acc);
    bit ok = 0;
    exp_t e;
    @(posedge clk); #1;
    bus.in_a = a;
    bus.in_b = b;
`ifdef VEDIC32_SIGNED_EN
    bus.in_signed = s;
`endif
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    acc = cyc + 1;
    if (!ok) begin
      bound_fail("accept");
      bus.in_valid = 1'b0;
      return;
    end
    exp_count = exp_count + 1'b1;
    e.p = p; e.cnt = exp_count; e.acc_cyc = acc;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_a = ~a;
    bus.in_b = ~b;
`ifdef VEDIC32_SIGNED_EN
    bus.in_signed = ~s;
`endif
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) bound_fail("drain");
    repeat (3) @(negedge clk);
  endtask

  // Monitor: latency on first out_valid, product and count on each hand-off
  initial begin
    bit   seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_output: out_p %h with nothing expected (cycle %0d)", bus.out_p, cyc);
        end else begin
          if (!seen) begin
            seen = 1;
            chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(LAT));
          end
          if (bus.out_ready) begin
            e = sb.pop_front();
            seen = 0;
            chk("out_p", bus.out_p, e.p);
            @(negedge clk);
            chk("op_count", 64'(op_count), 64'(e.cnt));
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int unsigned acc0, acc1, acc2;
    bit ok;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
`ifdef VEDIC32_SIGNED_EN
    bus.in_signed = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",      64'(busy),          64'd0);
    chk("rst_out_p",     bus.out_p,          64'd0);
    chk("rst_op_count",  64'(op_count),      64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic, cross terms, max
    issue(32'h0000FFFF, 32'h0000FFFF, 1'b0, 64'h00000000FFFE0001, 0, acc0);
    issue(32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000, 0, acc0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 0, acc0);
    drain();

    // Backpressure with ignored operand pulses
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(32'h12345678, 32'h00000010, 1'b0, 64'h0000000123456780, 0, acc0);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin ok = 1; break; end
    end
    if (!ok) bound_fail("bp_out_valid");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid = i[0];
      bus.in_a = 32'd3;
      bus.in_b = 32'd5;
      @(negedge clk);
      chk("bp_out_p",     bus.out_p,          64'h0000000123456780);
      chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
      chk("bp_busy",      64'(busy),          64'd1);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    drain();

    // Reset while cnt=2
    issue(32'h00000007, 32'h00000009, 1'b0, 64'h000000000000003F, 0, acc0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    exp_count = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",      64'(busy),          64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("mid_rst_out_p",     bus.out_p,          64'd0);
    chk("mid_rst_op_count",  64'(op_count),      64'd0);
    repeat (12) @(negedge clk);

    // Back-to-back with in_valid held
    issue(32'h00000002, 32'h00000003, 1'b0, 64'h0000000000000006, 1, acc0);
    issue(32'h00010000, 32'h00000010, 1'b0, 64'h0000000000100000, 1, acc1);
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000FFFFFFFF, 1, acc2);
    bus.in_valid = 1'b0;
    chk("b2b_gap1", 64'(acc1 - acc0), 64'd6);
    chk("b2b_gap2", 64'(acc2 - acc1), 64'd6);
    drain();

    // Further vectors carrying op_count through its wrap
    issue(32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000, 0, acc0);
    issue(32'h0000FFFF, 32'h00010000, 1'b0, 64'h00000000FFFF0000, 0, acc0);
    issue(32'hFFFF0000, 32'hFFFF0000, 1'b0, 64'hFFFE000100000000, 0, acc0);
    issue(32'h00000100, 32'h00000100, 1'b0, 64'h0000000000010000, 0, acc0);
    issue(32'hFFFFFFFF, 32'h00000010, 1'b0, 64'h0000000FFFFFFFF0, 0, acc0);
    issue(32'h12345678, 32'h00000000, 1'b0, 64'h0000000000000000, 0, acc0);
    drain();

`ifdef VEDIC32_SIGNED_EN
    issue(32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFFFFFFFFFE, 0, acc0);
    issue(32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h00000001FFFFFFFE, 0, acc0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vedic32_seq_ctrl.md
Name: vedic32_seq_ctrl

Overview:
Sequencing controller that computes a 32x32 -> 64-bit product by time-sharing a single vedic_16x16 instance over four cycles.
Latches operands on a valid/ready handshake, steps through the four 16-bit half-products, shift-accumulates them into a 64-bit register, and presents the result on a second valid/ready handshake.
Sits between the operand source and the result consumer. Replaces a full-area 32x32 array where throughput is not critical.

Parameters:
OP_W, 32, operand width; only 32 is supported, and half width is OP_W/2 = 16 to match vedic_16x16.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
in_a  input  OP_W  multiplicand
in_b  input  OP_W  multiplier
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
out_p  output  2*OP_W  product
busy  output  1  high in any state other than IDLE
op_count  output  CNT_W  completed (handed-off) products, wraps at 2^CNT_W

Behaviour:
- Reset (rst_n=0 at a rising edge) forces the following: state=IDLE, cnt=0, acc=0, a_r/b_r=0, op_count=0, in_ready=1, out_valid=0, busy=0, out_p=0.
- Reset mid-operation discards the operation in flight; nothing is emitted.
- States: IDLE, MUL, [CORR], DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE: when in_valid & in_ready, latch in_a->a_r and in_b->b_r, set acc=0 and cnt=0, then go to MUL. in_valid is ignored in all other states.
- MUL: each cycle, drive the shared vedic_16x16 with the half pair selected by cnt:
  - cnt 0: a_r[15:0] x b_r[15:0], shift 0
  - cnt 1: a_r[31:16] x b_r[15:0], shift 16
  - cnt 2: a_r[15:0] x b_r[31:16], shift 16
  - cnt 3: a_r[31:16] x b_r[31:16], shift 32
  - Each cycle, acc <= acc + zero-extended(pp) << shift, modulo 2^64; cnt increments.
  - At cnt=3, go to DONE (or CORR when the macro is enabled).
- DONE: out_p=acc, held stable together with out_valid until out_ready. On out_valid & out_ready: op_count++ (wraps), then go to IDLE.
- Latency: out_valid is high 4 cycles after the accepting edge (5 with VEDIC32_SIGNED_EN).
- Throughput: one op per 6 cycles with out_ready held high; there is no accept in the same cycle as hand-off.
- The multiplier is combinational. acc is the only pipeline register on the product path.
- in_a/in_b may change after the accept without effect on the operation in flight.

Optional Feature:
Macro VEDIC32_SIGNED_EN.
- Defined:
  - Adds input port in_signed (1 bit), latched with the operands.
  - Adds state CORR, entered after MUL cnt=3, lasting one cycle.
  - CORR: if signed_r, acc <= acc - (a_r[31] ? {b_r,32'b0} : 0) - (b_r[31] ? {a_r,32'b0} : 0), modulo 2^64; then go to DONE.
  - CORR is traversed even when signed_r=0, so latency stays fixed at 5.
- Undefined: no in_signed port, no CORR state, unsigned product only, latency 4.

Decomposition:
- Shared package vedic_pkg holds:
  - state enum (IDLE, MUL, CORR, DONE)
  - OP_W, HALF_W, NUM_PP=4 constants
  - per-index shift constants {0,16,16,32}
- One sub-module: the existing vedic_16x16, instantiated exactly once.
- The half-select mux, accumulator and FSM live in vedic32_seq_ctrl.

Test Plan:
- Basic: a=0x0000FFFF, b=0x0000FFFF, out_ready=1 -> out_p=0x00000000FFFE0001; out_valid 4 cycles after accept; op_count=1.
- Cross terms: a=0x00010000, b=0x00010000 -> 0x0000000100000000. Max: a=b=0xFFFFFFFF -> 0xFFFFFFFE00000001.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, pulsing in_valid with new operands.
  - Required: out_p stable, in_ready=0, busy=1, new operands ignored.
  - Releasing out_ready: hand-off in that cycle, in_ready=1 next cycle.
- Reset mid-op: assert rst_n=0 for 1 cycle when cnt=2 -> next cycle state IDLE, out_valid=0, in_ready=1, out_p=0, op_count=0, and no product is ever emitted.
- Back-to-back: 3 ops with in_valid held and out_ready=1 -> accepts exactly every 6 cycles, op_count=3.
  - Also: op_count preloaded near 2^CNT_W-1 wraps to 0.
- Signed (VEDIC32_SIGNED_EN):
  - a=0xFFFFFFFF, b=2, in_signed=1 -> 0xFFFFFFFFFFFFFFFE.
  - Same operands, in_signed=0 -> 0x00000001FFFFFFFE.
  - Latency 5 in both cases.
